// File: rtl/ir_sched_pkg.sv
// Shared types and constants for the IR frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ir_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  // Frame segment widths of the IR transmitter
  localparam int DATA35_W = 35;
  localparam int DATA32_W = 32;

  // Timing at the 125 MHz system clock
  localparam int CLK_HZ        = 125_000_000;
  localparam int GAP_100MS     = CLK_HZ / 10;
  localparam int TIMEOUT_200MS = CLK_HZ / 5;

endpackage

// File: rtl/ir_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after ptr (wrapping) wins.
// Latency: purely combinational.
// Backpressure: none; the parent decides whether the grant is used.
module ir_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  // Scan NREQ positions starting at ptr; the first hit is the winner
  always_comb begin
    logic [31:0]      idx;
    logic [PTR_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + 32'(k);
      if (idx >= 32'(NREQ)) begin
        idx = idx - 32'(NREQ);
      end
      sel = idx[PTR_W-1:0];
      if (!any_grant && req[sel]) begin
        any_grant  = 1'b1;
        grant_idx  = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_frame_scheduler.sv
// Shares one IR transmitter between NREQ command sources: round-robin grant, REPEAT sends, gap, watchdog.
// Latency: accept in cycle N gives tx_start in N+1; frame_sent one cycle after tx_done.
// Backpressure: req_ready only while IDLE; a requester holds req_valid until it sees req_ready.
module ir_frame_scheduler
  import ir_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int REPEAT      = 2,
  parameter int GAP_CYC     = GAP_100MS,
  parameter int TIMEOUT_CYC = TIMEOUT_200MS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*DATA35_W-1:0]     req_data35,
  input  logic [NREQ*DATA32_W-1:0]     req_data32,
  output logic                         tx_start,
  output logic [DATA35_W-1:0]          tx_data35,
  output logic [DATA32_W-1:0]          tx_data32,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic                         sched_busy,
  output logic                         frame_sent,
  output logic                         err_timeout
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int REP_W = $clog2(REPEAT) + 1;
  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REPEAT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};
  localparam logic [WD_W-1:0]  WD_MAX   = {WD_W{1'b1}};
  // Firing one count early lets err_timeout rise on the same edge the
  // watchdog value reaches TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles after tx_start.
  localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(TIMEOUT_CYC - 2);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [REP_W-1:0]      rep_q, rep_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [DATA35_W-1:0]   d35_q, d35_d;
  logic [DATA32_W-1:0]   d32_q, d32_d;
  logic [PTR_W-1:0]      gid_q, gid_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;
  logic                  fsent_q, fsent_d;

  logic [NREQ-1:0]       arb_grant;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  accept;
  logic [DATA35_W-1:0]   sel35;
  logic [DATA32_W-1:0]   sel32;

  ir_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Offer the grant only when idle and not in reset, so accept is just "any ready"
  assign accept    = (state_q == IDLE) && !rst && arb_any;
  assign req_ready = accept ? arb_grant : '0;

  // Select the winner's payload; the grant is one-hot so a plain OR-style scan is enough
  always_comb begin
    sel35 = '0;
    sel32 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel35 = req_data35[i*DATA35_W +: DATA35_W];
        sel32 = req_data32[i*DATA32_W +: DATA32_W];
      end
    end
  end

  // Next-state logic: accept, start pulse, wait for done or watchdog, silent gap, repeat
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    d35_d   = d35_q;
    d32_d   = d32_q;
    gid_d   = gid_q;
    err_d   = err_q;
    start_d = 1'b0;
    fsent_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          d35_d   = sel35;
          d32_d   = sel32;
          gid_d   = arb_idx;
          ptr_d   = (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_W'(1);
          rep_d   = '0;
          err_d   = 1'b0;
          state_d = START;
          start_d = 1'b1;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        if (tx_done) begin
          // A done arriving on the watchdog limit still counts as a good frame
          fsent_d = 1'b1;
          rep_d   = (rep_q == REP_MAX) ? rep_q : rep_q + REP_W'(1);
          gap_d   = '0;
          state_d = GAP;
        end else if (wd_q == WD_LIM) begin
          err_d   = 1'b1;
          rep_d   = REP_MAX;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        // A still-busy transmitter freezes the gap count, stretching the silence
        if (!tx_busy) begin
          if (gap_q == GAP_LAST) begin
            if (rep_q < REP_MAX) begin
              state_d = START;
              start_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      d35_q   <= '0;
      d32_q   <= '0;
      gid_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      fsent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      d35_q   <= d35_d;
      d32_q   <= d32_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
      start_q <= start_d;
      fsent_q <= fsent_d;
    end
  end

  assign tx_start    = start_q;
  assign tx_data35   = d35_q;
  assign tx_data32   = d32_q;
  assign grant_id    = gid_q;
  assign sched_busy  = (state_q != IDLE);
  assign frame_sent  = fsent_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ir_frame_scheduler.sv
// Self-checking bench for ir_frame_scheduler with a scoreboard of timed events.
// Latency: n/a.
// Backpressure: n/a.
module tb_ir_frame_scheduler;

  localparam int NREQ        = 4;
  localparam int REPEAT      = 2;
  localparam int GAP_CYC     = 20;
  localparam int TIMEOUT_CYC = 100;

  localparam int K_ACCEPT = 0;
  localparam int K_START  = 1;
  localparam int K_FRAME  = 2;
  localparam int K_ERR    = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = 4'b1111;
  logic [3:0]   req_ready;
  logic [139:0] req_data35;
  logic [127:0] req_data32;
  logic         tx_start;
  logic [34:0]  tx_data35;
  logic [31:0]  tx_data32;
  logic         tx_busy = 1'b0;
  logic         tx_done = 1'b0;
  logic [1:0]   grant_id;
  logic         sched_busy;
  logic         frame_sent;
  logic         err_timeout;

  ir_frame_scheduler #(
    .NREQ        (NREQ),
    .REPEAT      (REPEAT),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data35  (req_data35),
    .req_data32  (req_data32),
    .tx_start    (tx_start),
    .tx_data35   (tx_data35),
    .tx_data32   (tx_data32),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .frame_sent  (frame_sent),
    .err_timeout (err_timeout)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    int          cyc;
    int          id;
    logic [34:0] d35;
    logic [31:0] d32;
  } ev_t;
  ev_t exp_q[$];

  logic [34:0] pay35 [4];
  logic [31:0] pay32 [4];

  always_comb begin
    req_data35 = '0;
    req_data32 = '0;
    for (int i = 0; i < 4; i++) begin
      req_data35[35*i +: 35] = pay35[i];
      req_data32[32*i +: 32] = pay32[i];
    end
  end

  // Transmitter behaviour knobs: busy while tcnt < md_busy_len, done at tcnt == md_done
  // (0 = never), then busy again for md_post cycles.
  int md_busy_len = 31;
  int md_done     = 31;
  int md_post     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int id);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.id   = id;
    e.d35  = pay35[id];
    e.d32  = pay32[id];
    exp_q.push_back(e);
  endtask

  // One command with a well-behaved transmitter: frame = 1 start + 30 busy + done, gap 20
  task automatic push_cmd(input int a, input int id);
    push_ev(K_ACCEPT, a,      id);
    push_ev(K_START,  a + 1,  id);
    push_ev(K_FRAME,  a + 33, id);
    push_ev(K_START,  a + 53, id);
    push_ev(K_FRAME,  a + 85, id);
  endtask

  task automatic obs(input int kind, input int id);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, nothing expected", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    chk($sformatf("event_cycle_k%0d", kind), 64'(cyc), 64'(e.cyc));
    if (kind == K_ACCEPT) chk("accept_id", 64'(id), 64'(e.id));
    if (kind == K_START) begin
      chk("start_grant_id", 64'(grant_id), 64'(e.id));
      chk("start_data35", 64'(tx_data35), 64'(e.d35));
      chk("start_data32", 64'(tx_data32), 64'(e.d32));
    end
  endtask

  // Monitor: turns DUT outputs into events and checks handshake/stability rules
  logic        err_prev;
  logic        pbusy;
  logic [34:0] p35;
  logic [31:0] p32;
  initial begin
    int  aid;
    logic bad;
    err_prev = 1'b0;
    pbusy    = 1'b0;
    p35      = '0;
    p32      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        err_prev = err_timeout;
        pbusy    = 1'b0;
        continue;
      end
      if (|(req_valid & req_ready)) begin
        aid = 0;
        for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) aid = i;
        obs(K_ACCEPT, aid);
      end
      if (tx_start) obs(K_START, 0);
      if (frame_sent) obs(K_FRAME, 0);
      if (err_timeout && !err_prev) obs(K_ERR, 0);
      err_prev = err_timeout;
      bad = ($countones(req_ready) > 1) || (sched_busy && (req_ready != 4'b0)) ||
            (pbusy && sched_busy && ((tx_data35 != p35) || (tx_data32 != p32)));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL protocol: ready=%b busy=%0d data35=%0h held35=%0h (cycle %0d)",
                 req_ready, sched_busy, tx_data35, p35, cyc);
      end
      p35   = tx_data35;
      p32   = tx_data32;
      pbusy = sched_busy;
    end
  end

  // Transmitter model, sharing rst with the scheduler
  int   tcnt = 0;
  logic m_st;
  logic m_r;
  initial begin
    forever begin
      @(negedge clk);
      m_st = tx_start;
      m_r  = rst;
      @(posedge clk);
      #1;
      if (m_r) tcnt = 0;
      else if (m_st) tcnt = 1;
      else if (tcnt > 0 && tcnt < 250) tcnt++;
      else tcnt = 0;
      tx_done = (md_done > 0) && (tcnt == md_done);
      tx_busy = ((tcnt >= 1) && (tcnt < md_busy_len)) ||
                ((md_done > 0) && (tcnt > md_done) && (tcnt <= md_done + md_post));
    end
  end

  task automatic wait_idle(input int max);
    bit got = 0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (!sched_busy) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: sched_busy still %0d after %0d cycles", sched_busy, max);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int id);
    bit got = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL hold_accept: req_ready[%0d] never rose, got %b", id, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  initial begin
    int a;
    int b;
    pay35[0] = 35'h1_2345_6789; pay32[0] = 32'hDEAD_BEEF;
    pay35[1] = 35'h7_FFFF_FFFF; pay32[1] = 32'h0000_0001;
    pay35[2] = 35'h4_0210_0A52; pay32[2] = 32'h0080_000C;
    pay35[3] = 35'h0_0000_0001; pay32[3] = 32'hFFFF_FFFF;

    // Reset with every requester asking
    rst = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_tx_start", 64'(tx_start), 64'h0);
    chk("rst_err_timeout", 64'(err_timeout), 64'h0);
    chk("rst_sched_busy", 64'(sched_busy), 64'h0);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    chk("rst_tx_data35", 64'(tx_data35), 64'h0);
    chk("rst_frame_sent", 64'(frame_sent), 64'h0);

    // Contention: grants 0,1,2,3,0, each command 105 cycles long
    @(posedge clk);
    #1;
    rst = 1'b0;
    a = cyc;
    for (int k = 0; k < 5; k++) push_cmd(a + 105 * k, k % 4);
    repeat (421) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    wait_idle(400);

    // Single request from requester 2
    a = cyc;
    push_cmd(a, 2);
    req_valid = 4'b0100;
    hold(2);
    wait_idle(400);
    chk("single_grant_id", 64'(grant_id), 64'h2);

    // Transmitter hang: error 100 cycles after tx_start, no repeat, 20-cycle gap
    md_busy_len = 31; md_done = 0; md_post = 0;
    a = cyc;
    push_ev(K_ACCEPT, a, 1);
    push_ev(K_START, a + 1, 1);
    push_ev(K_ERR, a + 101, 1);
    req_valid = 4'b0010;
    hold(1);
    repeat (119) @(posedge clk);
    #1;
    @(negedge clk);
    chk("timeout_gap_last_busy", 64'(sched_busy), 64'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("timeout_idle", 64'(sched_busy), 64'h0);
    chk("timeout_err_sticky", 64'(err_timeout), 64'h1);
    md_busy_len = 31; md_done = 31; md_post = 0;
    @(posedge clk);
    #1;
    a = cyc;
    push_cmd(a, 0);
    req_valid = 4'b0001;
    hold(0);
    @(negedge clk);
    chk("err_cleared_on_accept", 64'(err_timeout), 64'h0);
    wait_idle(400);

    // Done on the watchdog limit, then busy 10 cycles into the gap
    md_busy_len = 99; md_done = 99; md_post = 10;
    a = cyc;
    push_ev(K_ACCEPT, a, 3);
    push_ev(K_START, a + 1, 3);
    push_ev(K_FRAME, a + 101, 3);
    push_ev(K_START, a + 131, 3);
    push_ev(K_FRAME, a + 231, 3);
    req_valid = 4'b1000;
    hold(3);
    wait_idle(400);
    chk("collision_no_err", 64'(err_timeout), 64'h0);

    // Reset while waiting for done, then a fresh request
    md_busy_len = 31; md_done = 31; md_post = 0;
    a = cyc;
    push_ev(K_ACCEPT, a, 2);
    push_ev(K_START, a + 1, 2);
    req_valid = 4'b0100;
    hold(2);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sched_busy", 64'(sched_busy), 64'h0);
    chk("midrst_tx_start", 64'(tx_start), 64'h0);
    chk("midrst_grant_id", 64'(grant_id), 64'h0);
    @(posedge clk);
    #1;
    b = cyc;
    push_cmd(b, 1);
    req_valid = 4'b0010;
    hold(1);
    wait_idle(400);

    repeat (5) @(posedge clk);
    chk("pending_events", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
